// File: rtl/fu_dispatch_ctrl.sv
// fu_dispatch_ctrl
// Decode-side issue controller for the functional-unit stage. Requests from
// decode are buffered in a 2-entry FIFO. The head entry is driven on the packed
// operand bus with a one-cycle start strobe (csr bit 0). The block then waits
// for the FU done status, captures result/status, and returns them to
// writeback over a valid/ready handshake. The head entry stays in the FIFO
// until its response handshake, so the occupancy count includes the in-flight
// request.
//
// Optional feature: define FU_TIMEOUT_EN to abort requests that see no done
// within TIMEOUT_CYC WAIT cycles. Aborts return result/status 0 with
// rsp_timeout = 1. Without the macro, WAIT waits forever and rsp_timeout is 0.
//
// Ports:
//   clk, reset            clock (rising edge), async active-low reset
//   req_valid/req_ready   decode request handshake (ready = FIFO not full)
//   req_a/b/op/csr        request payload (req_csr[0] ignored)
//   from_DE_to_FU         packed {a, b, op, csr} to the FU, zero when idle
//   from_FU_to_DE         packed {result, status}; status[0] = done
//   rsp_valid/rsp_ready   response handshake to writeback
//   rsp_result/status     captured FU output
//   rsp_timeout           response is an abort

`ifndef ALUDATABITS
`define ALUDATABITS 32
`endif
`ifndef ALUOPBITS
`define ALUOPBITS 4
`endif
`ifndef ALUCSRINBITS
`define ALUCSRINBITS 4
`endif
`ifndef ALUCSROUTBITS
`define ALUCSROUTBITS 4
`endif

module fu_dispatch_ctrl #(
  parameter int DATA_W      = `ALUDATABITS,
  parameter int OP_W        = `ALUOPBITS,
  parameter int CSRIN_W     = `ALUCSRINBITS,
  parameter int CSROUT_W    = `ALUCSROUTBITS,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [DATA_W-1:0]                req_a,
  input  logic [DATA_W-1:0]                req_b,
  input  logic [OP_W-1:0]                  req_op,
  input  logic [CSRIN_W-1:0]               req_csr,
  output logic [2*DATA_W+OP_W+CSRIN_W-1:0] from_DE_to_FU,
  input  logic [DATA_W+CSROUT_W-1:0]       from_FU_to_DE,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [DATA_W-1:0]                rsp_result,
  output logic [CSROUT_W-1:0]              rsp_status,
  output logic                             rsp_timeout
);

  typedef struct packed {
    logic [DATA_W-1:0]  a;
    logic [DATA_W-1:0]  b;
    logic [OP_W-1:0]    op;
    logic [CSRIN_W-1:0] csr;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t              r_state, w_state_nxt;
  req_t                r_mem [2];
  logic                r_wr_ptr, r_rd_ptr;
  logic [1:0]          r_count, w_count_nxt;
  logic                w_push, w_pop, w_done, w_timeout;
  req_t                w_req_in, w_head, w_bus;
  logic [DATA_W-1:0]   w_fu_result;
  logic [CSROUT_W-1:0] w_fu_status;
  logic [DATA_W-1:0]   r_result;
  logic [CSROUT_W-1:0] r_status;
  logic                r_timeout;

  assign w_fu_result = from_FU_to_DE[DATA_W+CSROUT_W-1:CSROUT_W];
  assign w_fu_status = from_FU_to_DE[CSROUT_W-1:0];

  // ---------------- FIFO ----------------
  assign req_ready   = (r_count < 2'd2);
  assign w_push      = req_valid & req_ready;
  assign w_pop       = (r_state == S_RESP) & rsp_ready;
  assign w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};

  // Start bit is owned here: store csr with bit 0 cleared, set it only in ISSUE.
  assign w_req_in = {req_a, req_b, req_op, req_csr & ~CSRIN_W'(1)};

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_req_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= w_count_nxt;
    end
  end

  // ---------------- timeout ----------------
`ifdef FU_TIMEOUT_EN
  localparam int TCNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [TCNT_W-1:0] r_tcnt;

  // r_tcnt holds the number of WAIT cycles already completed, so the
  // TIMEOUT_CYC-th WAIT cycle is the one where it reads TIMEOUT_CYC-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 r_tcnt <= '0;
    else if (r_state != S_WAIT) r_tcnt <= '0;
    else                        r_tcnt <= r_tcnt + TCNT_W'(1);
  end

  // Done wins over a coincident timeout.
  assign w_timeout = (r_state == S_WAIT) && !w_fu_status[0] &&
                     (r_tcnt == TCNT_W'(TIMEOUT_CYC - 1));
`else
  logic w_unused_tcyc;
  assign w_unused_tcyc = (TIMEOUT_CYC != 0);
  assign w_timeout     = 1'b0;
`endif

  // Done is only meaningful in WAIT; a done seen during ISSUE is stale.
  assign w_done = (r_state == S_WAIT) && w_fu_status[0];

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (r_count != 2'd0) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (w_done || w_timeout) w_state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) w_state_nxt = (w_count_nxt != 2'd0) ? S_ISSUE : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- response capture ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_result  <= '0;
      r_status  <= '0;
      r_timeout <= 1'b0;
    end else if (w_done) begin
      r_result  <= w_fu_result;
      r_status  <= w_fu_status;
      r_timeout <= 1'b0;
    end else if (w_timeout) begin
      r_result  <= '0;
      r_status  <= '0;
      r_timeout <= 1'b1;
    end
  end

  // ---------------- outputs ----------------
  always_comb begin
    w_bus  = '0;
    w_head = r_mem[r_rd_ptr];
    if (r_state == S_ISSUE || r_state == S_WAIT) begin
      w_bus        = w_head;
      w_bus.csr[0] = (r_state == S_ISSUE);
    end
  end

  assign from_DE_to_FU = w_bus;
  assign rsp_valid     = (r_state == S_RESP);
  assign rsp_result    = r_result;
  assign rsp_status    = r_status;
  assign rsp_timeout   = r_timeout;

endmodule

// File: tb/tb_fu_dispatch_ctrl.sv
module tb_fu_dispatch_ctrl;
  localparam int DW  = 32;
  localparam int OW  = 4;
  localparam int CIW = 4;
  localparam int COW = 4;
  localparam int TO  = 4;
  localparam int BW  = 2*DW + OW + CIW;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic [DW-1:0]  req_a = '0, req_b = '0;
  logic [OW-1:0]  req_op = '0;
  logic [CIW-1:0] req_csr = '0;
  logic [BW-1:0]  from_DE_to_FU;
  logic [DW+COW-1:0] from_FU_to_DE = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [DW-1:0]  rsp_result;
  logic [COW-1:0] rsp_status;
  logic           rsp_timeout;

  fu_dispatch_ctrl #(.DATA_W(DW), .OP_W(OW), .CSRIN_W(CIW), .CSROUT_W(COW),
                     .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_csr(req_csr),
    .from_DE_to_FU(from_DE_to_FU), .from_FU_to_DE(from_FU_to_DE),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_status(rsp_status), .rsp_timeout(rsp_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0]  res;
    logic [COW-1:0] st;
    logic           to;
  } rsp_t;

  rsp_t sb[$];     // expected responses, pushed when a request is driven
  rsp_t got[$];    // observed response handshakes
  int   start_cyc[$];
  int   cyc = 0;
  int   n_chk = 0, n_pass = 0;
  bit   alu_manual = 1'b0;
  int   alu_lat = 1;

  function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a, b, input logic [OW-1:0] op);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      default: return a ^ b;
    endcase
  endfunction

  function automatic logic [COW-1:0] alu_st(input logic [OW-1:0] op);
    return {op[2:0], 1'b1};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitors: start pulses and response handshakes.
  rsp_t mon_r;
  always @(negedge clk) begin
    if (from_DE_to_FU[0]) start_cyc.push_back(cyc);
    if (reset && rsp_valid && rsp_ready) begin
      mon_r.res = rsp_result; mon_r.st = rsp_status; mon_r.to = rsp_timeout;
      got.push_back(mon_r);
    end
  end

  // ALU model: done alu_lat cycles after the start cycle, for one cycle.
  int cd = 0;
  logic [DW-1:0] ma = '0, mb = '0;
  logic [OW-1:0] mop = '0;
  always @(posedge clk) begin
    #1;
    if (!reset) cd = 0;
    else if (!alu_manual) begin
      from_FU_to_DE = '0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) from_FU_to_DE = {alu_f(ma, mb, mop), alu_st(mop)};
      end
      if (from_DE_to_FU[0]) begin
        ma  = from_DE_to_FU[BW-1 -: DW];
        mb  = from_DE_to_FU[BW-DW-1 -: DW];
        mop = from_DE_to_FU[CIW+OW-1 -: OW];
        cd  = alu_lat;
      end
    end
  end

  task automatic sb_push(input logic [DW-1:0] a, b, input logic [OW-1:0] op, input bit to);
    rsp_t e;
    e.res = to ? '0 : alu_f(a, b, op);
    e.st  = to ? '0 : alu_st(op);
    e.to  = to;
    sb.push_back(e);
  endtask

  // Drives one request and returns #1 after the accepting edge.
  task automatic drive_req(input logic [DW-1:0] a, b, input logic [OW-1:0] op);
    int t;
    @(negedge clk);
    req_a = a; req_b = b; req_op = op; req_csr = 4'b0111; req_valid = 1'b1;
    t = 0;
    while (!req_ready && t < 300) begin @(negedge clk); t++; end
    if (!req_ready) begin
      n_chk++;
      $display("FAIL req_accept: req_ready stayed %b, wanted 1 within bound", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic get_rsp(output bit ok, output rsp_t r);
    ok = 1'b0;
    r.res = '0; r.st = '0; r.to = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (got.size() != 0) begin
        r = got.pop_front();
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic clear_queues();
    while (got.size() != 0) void'(got.pop_front());
    sb.delete();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_chk++;
    if (req_ready !== 1'b1) $display("FAIL rst_req_ready: got %b want 1", req_ready);
    else n_pass++;
    n_chk++;
    if (from_DE_to_FU !== '0) $display("FAIL rst_bus: got %h want 0", from_DE_to_FU);
    else n_pass++;
    n_chk++;
    if ({rsp_valid, rsp_result, rsp_status, rsp_timeout} !== '0)
      $display("FAIL rst_rsp: got v=%b r=%h s=%h t=%b want all 0", rsp_valid, rsp_result, rsp_status, rsp_timeout);
    else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    n_chk++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || from_DE_to_FU !== '0)
      $display("FAIL rst_release: got v=%b rdy=%b bus=%h want 0/1/0", rsp_valid, req_ready, from_DE_to_FU);
    else n_pass++;
  endtask

  task automatic test_single();
    rsp_t e;
    int   base;
    alu_manual = 1'b0; alu_lat = 1; rsp_ready = 1'b1;
    clear_queues();
    base = start_cyc.size();
    sb_push(5, 7, 0, 1'b0);
    drive_req(5, 7, 0);                       // accepted at edge N
    @(negedge clk);                           // cycle N: still IDLE
    @(negedge clk);                           // cycle N+1: ISSUE
    n_chk++;
    if (from_DE_to_FU !== {32'd5, 32'd7, 4'd0, 4'b0111})
      $display("FAIL single_issue_bus: got %h want start bus", from_DE_to_FU);
    else n_pass++;
    @(negedge clk);                           // cycle N+2: WAIT
    n_chk++;
    if (from_DE_to_FU !== {32'd5, 32'd7, 4'd0, 4'b0110} || rsp_valid !== 1'b0)
      $display("FAIL single_wait_bus: got bus=%h v=%b want held bus, strobe 0", from_DE_to_FU, rsp_valid);
    else n_pass++;
    @(negedge clk);                           // cycle N+3: RESP
    e = sb.pop_front();
    n_chk++;
    if (rsp_valid !== 1'b1 || rsp_result !== e.res || rsp_status !== e.st || rsp_timeout !== e.to)
      $display("FAIL single_rsp: got v=%b r=%0d s=%h t=%b want v=1 r=%0d s=%h t=%b",
               rsp_valid, rsp_result, rsp_status, rsp_timeout, e.res, e.st, e.to);
    else n_pass++;
    @(negedge clk);                           // cycle N+4: back to IDLE
    n_chk++;
    if (rsp_valid !== 1'b0 || from_DE_to_FU !== '0)
      $display("FAIL single_after: got v=%b bus=%h want 0/0", rsp_valid, from_DE_to_FU);
    else n_pass++;
    n_chk++;
    if (start_cyc.size() - base !== 1)
      $display("FAIL single_starts: got %0d start pulses want 1", start_cyc.size() - base);
    else n_pass++;
  endtask

  task automatic test_fill_backpressure();
    rsp_t r, e;
    bit   ok;
    int   t;
    logic [DW-1:0] h;
    alu_manual = 1'b0; alu_lat = 2; rsp_ready = 1'b0;
    clear_queues();
    sb_push(100, 20, 1, 1'b0); drive_req(100, 20, 1);
    sb_push(3, 4, 2, 1'b0);    drive_req(3, 4, 2);
    @(negedge clk);
    n_chk++;
    if (req_ready !== 1'b0) $display("FAIL fill_full: req_ready got %b want 0", req_ready);
    else n_pass++;
    // third request waits on a full FIFO
    req_a = 9; req_b = 9; req_op = 0; req_csr = 4'b0111; req_valid = 1'b1;
    sb_push(9, 9, 0, 1'b0);
    t = 0;
    while (!rsp_valid && t < 50) begin @(negedge clk); t++; end
    h = rsp_result;
    repeat (3) @(negedge clk);
    n_chk++;
    if (rsp_valid !== 1'b1 || rsp_result !== h || req_ready !== 1'b0 || h !== 32'd80)
      $display("FAIL fill_hold: got v=%b r=%0d rdy=%b want v=1 r=80 held rdy=0", rsp_valid, rsp_result, req_ready);
    else n_pass++;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk);                           // handshake edge H (pop only)
    @(negedge clk);
    n_chk++;
    if (req_ready !== 1'b1)
      $display("FAIL fill_no_bypass: req_ready got %b want 1 (third not yet taken)", req_ready);
    else n_pass++;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      get_rsp(ok, r);
      n_chk++;
      if (!ok || sb.size() == 0) $display("FAIL fill_rsp%0d: got no response want one", k);
      else begin
        e = sb.pop_front();
        if (r.res !== e.res || r.st !== e.st || r.to !== e.to)
          $display("FAIL fill_rsp%0d: got r=%h s=%h t=%b want r=%h s=%h t=%b", k, r.res, r.st, r.to, e.res, e.st, e.to);
        else n_pass++;
      end
    end
  endtask

  task automatic test_stray_done();
    alu_manual = 1'b1; from_FU_to_DE = '0; rsp_ready = 1'b1;
    clear_queues();
    drive_req(32'h11, 32'h22, 0);
    @(negedge clk);                           // IDLE
    @(negedge clk);                           // ISSUE: done here must be ignored
    from_FU_to_DE = {32'hAAAA_AAAA, 4'b1111};
    @(negedge clk);                           // first WAIT
    from_FU_to_DE = {32'h0000_1234, 4'b0101};
    @(negedge clk);
    from_FU_to_DE = '0;
    n_chk++;
    if (rsp_valid !== 1'b1 || rsp_result !== 32'h1234 || rsp_status !== 4'b0101 || rsp_timeout !== 1'b0)
      $display("FAIL stray_capture: got v=%b r=%h s=%h t=%b want v=1 r=1234 s=5 t=0",
               rsp_valid, rsp_result, rsp_status, rsp_timeout);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (rsp_valid !== 1'b0) $display("FAIL stray_one_rsp: rsp_valid got %b want 0", rsp_valid);
    else n_pass++;
    alu_manual = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    bit bad;
    alu_manual = 1'b1; from_FU_to_DE = '0; rsp_ready = 1'b1;
    clear_queues();
    drive_req(1, 2, 0);
    drive_req(3, 4, 0);
    @(negedge clk);                           // ISSUE
    @(negedge clk);                           // WAIT, one entry queued behind
    n_chk++;
    if (from_DE_to_FU === '0 || from_DE_to_FU[0] !== 1'b0)
      $display("FAIL rmid_wait: got bus=%h want held payload with strobe 0", from_DE_to_FU);
    else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_chk++;
    if (from_DE_to_FU !== '0 || rsp_valid !== 1'b0 || rsp_result !== '0 || rsp_status !== '0 ||
        rsp_timeout !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL rmid_async: got bus=%h v=%b r=%h s=%h t=%b rdy=%b want zeros, rdy=1",
               from_DE_to_FU, rsp_valid, rsp_result, rsp_status, rsp_timeout, req_ready);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    from_FU_to_DE = {32'hDEAD_BEEF, 4'b0001};   // late done
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || from_DE_to_FU !== '0) bad = 1'b1;
    end
    from_FU_to_DE = '0;
    n_chk++;
    if (bad) $display("FAIL rmid_late_done: got activity after reset want none");
    else n_pass++;
    n_chk++;
    if (req_ready !== 1'b1) $display("FAIL rmid_ready: got %b want 1", req_ready);
    else n_pass++;
    alu_manual = 1'b0;
  endtask

  task automatic test_back_to_back();
    rsp_t r, e;
    bit   ok;
    int   base;
    alu_manual = 1'b0; alu_lat = 3; rsp_ready = 1'b1;
    clear_queues();
    base = start_cyc.size();
    sb_push(10, 1, 0, 1'b0); drive_req(10, 1, 0);
    sb_push(10, 1, 1, 1'b0); drive_req(10, 1, 1);
    sb_push(10, 1, 2, 1'b0); drive_req(10, 1, 2);
    for (int k = 0; k < 3; k++) begin
      get_rsp(ok, r);
      n_chk++;
      if (!ok || sb.size() == 0) $display("FAIL b2b_rsp%0d: got no response want one", k);
      else begin
        e = sb.pop_front();
        if (r.res !== e.res || r.st !== e.st || r.to !== e.to)
          $display("FAIL b2b_rsp%0d: got r=%h s=%h t=%b want r=%h s=%h t=%b", k, r.res, r.st, r.to, e.res, e.st, e.to);
        else n_pass++;
      end
    end
    n_chk++;
    if (start_cyc.size() - base !== 3)
      $display("FAIL b2b_starts: got %0d starts want 3", start_cyc.size() - base);
    else if (start_cyc[base+1] - start_cyc[base] !== 5 || start_cyc[base+2] - start_cyc[base+1] !== 5)
      $display("FAIL b2b_spacing: got %0d,%0d cycles want 5,5",
               start_cyc[base+1] - start_cyc[base], start_cyc[base+2] - start_cyc[base+1]);
    else n_pass++;
  endtask

`ifdef FU_TIMEOUT_EN
  task automatic test_timeout();
    rsp_t r, e;
    bit   ok;
    alu_manual = 1'b1; from_FU_to_DE = '0; rsp_ready = 1'b1;
    clear_queues();
    sb_push(6, 6, 0, 1'b1); drive_req(6, 6, 0);
    sb_push(8, 2, 1, 1'b0); drive_req(8, 2, 1);   // returns in ISSUE of the first
    repeat (5) @(negedge clk);                  // ISSUE + 4th WAIT
    n_chk++;
    if (rsp_valid !== 1'b0) $display("FAIL to_early: rsp_valid got %b want 0", rsp_valid);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b1 || rsp_result !== '0 || rsp_status !== '0)
      $display("FAIL to_resp: got v=%b t=%b r=%h s=%h want 1/1/0/0", rsp_valid, rsp_timeout, rsp_result, rsp_status);
    else n_pass++;
    alu_lat = 1;
    alu_manual = 1'b0;
    for (int k = 0; k < 2; k++) begin
      get_rsp(ok, r);
      n_chk++;
      if (!ok || sb.size() == 0) $display("FAIL to_rsp%0d: got no response want one", k);
      else begin
        e = sb.pop_front();
        if (r.res !== e.res || r.st !== e.st || r.to !== e.to)
          $display("FAIL to_rsp%0d: got r=%h s=%h t=%b want r=%h s=%h t=%b", k, r.res, r.st, r.to, e.res, e.st, e.to);
        else n_pass++;
      end
    end
  endtask

  task automatic test_timeout_tie();
    alu_manual = 1'b1; from_FU_to_DE = '0; rsp_ready = 1'b1;
    clear_queues();
    drive_req(1, 1, 0);                         // returns in cycle N
    repeat (6) @(negedge clk);                  // cycle N+5: 4th WAIT
    from_FU_to_DE = {32'h0000_0077, 4'b0011};
    @(negedge clk);
    from_FU_to_DE = '0;
    n_chk++;
    if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b0 || rsp_result !== 32'h77 || rsp_status !== 4'b0011)
      $display("FAIL tie_done_wins: got v=%b t=%b r=%h s=%h want 1/0/77/3", rsp_valid, rsp_timeout, rsp_result, rsp_status);
    else n_pass++;
    @(negedge clk);
    alu_manual = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fill_backpressure();
    test_stray_done();
    test_reset_mid_wait();
    test_back_to_back();
`ifdef FU_TIMEOUT_EN
    test_timeout();
    test_timeout_tie();
`endif
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
